ofm_channel_accumulator: RTL and testbench
==========================================

// Module: ofm_channel_accumulator
// PURPOSE
//  Downstream of the 9-input adder tree. Takes its signed per-channel partial sums (ofm_output)
//  and accumulates them over cfg_num_ch input channels for each output pixel.
//  Each finished sum is requantized (round, shift, optional ReLU, saturate) to an 8-bit signed OFM value.
//  Results go out on a valid/ready stream to the OFM write buffer. Frame length is cfg_num_px pixels.
// PARAMETERS
//  PSUM_WIDTH    20  width of signed partial sum from adder tree
//  ACC_WIDTH     28  width of signed channel accumulator (PSUM_WIDTH + log2 max channels)
//  OUT_WIDTH     8   width of signed requantized OFM output
//  CH_CNT_WIDTH  8   width of channel-count config/counter
//  PX_CNT_WIDTH  16  width of pixel-count config/counter
// PORTS
//  clk           in   1             single clock, rising edge
//  rst_n         in   1             asynchronous active-low reset
//  start         in   1             1-cycle pulse: latch cfg_*, begin a frame (ignored unless IDLE)
//  cfg_num_ch    in   CH_CNT_WIDTH  input channels per pixel; 0 treated as 1
//  cfg_num_px    in   PX_CNT_WIDTH  output pixels per frame; 0 treated as 1
//  cfg_shift     in   5             arithmetic right-shift amount for requant
//  cfg_relu_en   in   1             1: clamp negative results to 0
//  psum_valid    in   1             psum_in valid
//  psum_ready    out  1             accumulator accepts psum_in
//  psum_in       in   PSUM_WIDTH    signed partial sum (adder-tree output incl. bias)
//  ofm_valid     out  1             ofm_data valid
//  ofm_ready     in   1             consumer accepts ofm_data
//  ofm_data      out  OUT_WIDTH     signed requantized output pixel
//  busy          out  1             high in ACCUM or OUTPUT
//  done          out  1             1-cycle pulse after last pixel of frame handshaken
// BEHAVIOUR
//  Reset (async, any time incl. mid-frame): state=IDLE, acc=0, ch_cnt=0, px_cnt=0,
//   psum_ready=0, ofm_valid=0, ofm_data=0, busy=0, done=0. Partial results discarded.
//  FSM states IDLE, ACCUM, OUTPUT. All outputs registered except psum_ready=(state==ACCUM), busy.
//  IDLE: on start, latch cfg_* (0 -> 1). Clear acc/ch_cnt/px_cnt. Go to ACCUM.
//   start in ACCUM/OUTPUT is ignored. cfg_* may change freely after latch.
//  ACCUM: a beat is psum_valid && psum_ready.
//   Each beat: acc += sign-extend(psum_in), ch_cnt++.
//   Beat with ch_cnt==N_ch-1 (last): final = acc + sext(psum_in). Register ofm_data=requant(final),
//   ofm_valid=1, go to OUTPUT. ofm_valid rises the cycle after the last beat.
//  OUTPUT: psum_ready=0, so no psum is consumed. ofm_data/ofm_valid hold stable until ofm_ready.
//   On handshake: ofm_valid=0, acc=0, ch_cnt=0, px_cnt++.
//    If px_cnt was N_px-1: go to IDLE and pulse done for 1 cycle.
//    Otherwise go to ACCUM.
//   Throughput: one bubble cycle per pixel, taken in OUTPUT.
//  requant(x), in order:
//   r = (x + (shift>0 ? 1<<(shift-1) : 0)) >>> shift   (round half toward +inf, ACC_WIDTH+1 bits)
//   if relu_en && r<0: r=0
//   saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
//  Accumulator overflow wraps two's complement. ACC_WIDTH is sized so this cannot occur for
//   CH_CNT_WIDTH channels.
//  X/Z on psum_in during a beat propagates to ofm_data. No X masking.
// TESTING
//  1 N_ch=3,N_px=1,shift=0,relu=0; psums 10,20,16 back-to-back -> ofm_data=46 one cycle after
//    3rd beat; done pulses 1 cycle after handshake.
//  2 N_ch=1,shift=2; psum 6 -> 2; psum -6 -> -1; psum 5 -> 1; shift=0, psum -7 -> -7.
//  3 N_ch=2,shift=0; psums 524287,524287 -> 127. psums -524288,-524288 -> -128.
//    Same negatives with relu=1 -> 0.
//  4 Backpressure: ofm_ready=0 for 5 cycles with psum_valid=1 -> ofm_data stable,
//    psum_ready=0, no psum consumed. Next pixel accumulates correctly afterwards.
//  5 N_ch=4: rst_n=0 after 2 beats -> all outputs 0, IDLE. New start + psums 1,2,3,4 -> 10
//    (no stale sum).
//  6 N_px=3,N_ch=2, random psum_valid gaps, start pulsed mid-frame -> 3 correct outputs,
//    start ignored, done exactly once.

Source files
------------

// File: rtl/ofm_channel_accumulator.sv
// Accumulates adder-tree partial sums over the input channels of each output pixel, then
// requantizes (round, shift, optional ReLU, saturate) to a signed OFM byte on a valid/ready stream.
module ofm_channel_accumulator #(
   parameter int unsigned PSUM_WIDTH   = 20,
   parameter int unsigned ACC_WIDTH    = 28,
   parameter int unsigned OUT_WIDTH    = 8,
   parameter int unsigned CH_CNT_WIDTH = 8,
   parameter int unsigned PX_CNT_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [CH_CNT_WIDTH-1:0] cfg_num_ch,
   input  logic [PX_CNT_WIDTH-1:0] cfg_num_px,
   input  logic [4:0]              cfg_shift,
   input  logic                    cfg_relu_en,
   input  logic                    psum_valid,
   output logic                    psum_ready,
   input  logic [PSUM_WIDTH-1:0]   psum_in,
   output logic                    ofm_valid,
   input  logic                    ofm_ready,
   output logic [OUT_WIDTH-1:0]    ofm_data,
   output logic                    busy,
   output logic                    done
);

   typedef enum logic [1:0] {StIdle, StAccum, StOutput} state_e;

   localparam logic signed [ACC_WIDTH:0] SatMax =
      {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH:0] SatMin =
      {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [ACC_WIDTH:0] One = {{ACC_WIDTH{1'b0}}, 1'b1};

   state_e                   r_state, w_state_d;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic [CH_CNT_WIDTH-1:0]  r_ch_cnt, r_num_ch;
   logic [PX_CNT_WIDTH-1:0]  r_px_cnt, r_num_px;
   logic [4:0]               r_shift;
   logic                     r_relu;
   logic                     r_ofm_valid;
   logic [OUT_WIDTH-1:0]     r_ofm_data;
   logic                     r_done;

   logic                     w_start, w_beat, w_last_ch, w_out_hs, w_last_px;
   logic signed [ACC_WIDTH-1:0] w_psum_ext, w_final;
   logic signed [ACC_WIDTH:0] w_ext, w_rnd, w_rsum, w_shr, w_relu;
   logic [OUT_WIDTH-1:0]     w_req;

   assign w_start   = (r_state == StIdle) && start;
   assign w_beat    = (r_state == StAccum) && psum_valid;
   assign w_last_ch = (r_ch_cnt == r_num_ch - CH_CNT_WIDTH'(1));
   assign w_out_hs  = (r_state == StOutput) && ofm_ready;
   assign w_last_px = (r_px_cnt == r_num_px - PX_CNT_WIDTH'(1));

   assign w_psum_ext = {{(ACC_WIDTH-PSUM_WIDTH){psum_in[PSUM_WIDTH-1]}}, psum_in};
   assign w_final    = r_acc + w_psum_ext;

   // Round half toward +inf in ACC_WIDTH+1 bits so the rounding add cannot overflow.
   always_comb begin
      w_ext  = {w_final[ACC_WIDTH-1], w_final};
      w_rnd  = (r_shift == 5'd0) ? '0 : (One << (r_shift - 5'd1));
      w_rsum = w_ext + w_rnd;
      w_shr  = w_rsum >>> r_shift;
      w_relu = (r_relu && w_shr[ACC_WIDTH]) ? '0 : w_shr;
      w_req  = w_relu[OUT_WIDTH-1:0];
      if (w_relu > SatMax) begin
         w_req = SatMax[OUT_WIDTH-1:0];
      end else if (w_relu < SatMin) begin
         w_req = SatMin[OUT_WIDTH-1:0];
      end
   end

   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle:   if (start) w_state_d = StAccum;
         StAccum:  if (w_beat && w_last_ch) w_state_d = StOutput;
         StOutput: if (ofm_ready) w_state_d = w_last_px ? StIdle : StAccum;
         default:  w_state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc       <= '0;
         r_ch_cnt    <= '0;
         r_px_cnt    <= '0;
         r_num_ch    <= '0;
         r_num_px    <= '0;
         r_shift     <= '0;
         r_relu      <= 1'b0;
         r_ofm_valid <= 1'b0;
         r_ofm_data  <= '0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_start) begin
            r_num_ch <= (cfg_num_ch == '0) ? CH_CNT_WIDTH'(1) : cfg_num_ch;
            r_num_px <= (cfg_num_px == '0) ? PX_CNT_WIDTH'(1) : cfg_num_px;
            r_shift  <= cfg_shift;
            r_relu   <= cfg_relu_en;
            r_acc    <= '0;
            r_ch_cnt <= '0;
            r_px_cnt <= '0;
         end
         if (w_beat) begin
            r_acc    <= w_final;
            r_ch_cnt <= r_ch_cnt + CH_CNT_WIDTH'(1);
            if (w_last_ch) begin
               r_ofm_data  <= w_req;
               r_ofm_valid <= 1'b1;
            end
         end
         if (w_out_hs) begin
            r_ofm_valid <= 1'b0;
            r_acc       <= '0;
            r_ch_cnt    <= '0;
            r_px_cnt    <= r_px_cnt + PX_CNT_WIDTH'(1);
            r_done      <= w_last_px;
         end
      end
   end

   assign psum_ready = (r_state == StAccum);
   assign busy       = (r_state != StIdle);
   assign ofm_valid  = r_ofm_valid;
   assign ofm_data   = r_ofm_data;
   assign done       = r_done;

endmodule

// File: tb/tb_ofm_channel_accumulator.sv
// Directed bench for ofm_channel_accumulator: table of single-pixel vectors plus hand-written
// sequences for backpressure, mid-frame reset and a multi-pixel frame with gaps.
module tb_ofm_channel_accumulator;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [7:0]  cfg_num_ch;
   logic [15:0] cfg_num_px;
   logic [4:0]  cfg_shift;
   logic        cfg_relu_en;
   logic        psum_valid;
   logic        psum_ready;
   logic [19:0] psum_in;
   logic        ofm_valid;
   logic        ofm_ready;
   logic [7:0]  ofm_data;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_fail = 0;
   int done_cnt = 0;

   ofm_channel_accumulator dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .cfg_num_ch  (cfg_num_ch),
      .cfg_num_px  (cfg_num_px),
      .cfg_shift   (cfg_shift),
      .cfg_relu_en (cfg_relu_en),
      .psum_valid  (psum_valid),
      .psum_ready  (psum_ready),
      .psum_in     (psum_in),
      .ofm_valid   (ofm_valid),
      .ofm_ready   (ofm_ready),
      .ofm_data    (ofm_data),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   typedef struct {
      int nch;
      int shift;
      bit relu;
      int np;
      int p0;
      int p1;
      int p2;
      int p3;
      int exp;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic signed [31:0] act,
                      input logic signed [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic start_frame(input int nch, input int npx, input int sh, input bit rl);
      @(negedge clk);
      cfg_num_ch  = nch[7:0];
      cfg_num_px  = npx[15:0];
      cfg_shift   = sh[4:0];
      cfg_relu_en = rl;
      start       = 1'b1;
      @(negedge clk);
      start       = 1'b0;
      // Config is latched; scramble it to prove it is not re-read.
      cfg_num_ch  = 8'd7;
      cfg_num_px  = 16'd9;
      cfg_shift   = 5'd3;
      cfg_relu_en = ~rl;
   endtask

   task automatic feed(input int v);
      psum_valid = 1'b1;
      psum_in    = v[19:0];
      @(negedge clk);
      psum_valid = 1'b0;
   endtask

   task automatic take(input string name, input int exp, input bit last);
      chk({name, ".valid"}, ofm_valid, 1);
      chk({name, ".data"}, $signed(ofm_data), exp);
      chk({name, ".psum_ready"}, psum_ready, 0);
      ofm_ready = 1'b1;
      @(negedge clk);
      ofm_ready = 1'b0;
      chk({name, ".done"}, done, last);
      chk({name, ".valid_clr"}, ofm_valid, 0);
      if (last) begin
         @(negedge clk);
         chk({name, ".done_end"}, done, 0);
         chk({name, ".busy_end"}, busy, 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int base;
      vec_t v;
      vecs[0] = '{nch: 3, shift: 0, relu: 0, np: 3, p0: 10, p1: 20, p2: 16, p3: 0, exp: 46};
      vecs[1] = '{nch: 1, shift: 2, relu: 0, np: 1, p0: 6, p1: 0, p2: 0, p3: 0, exp: 2};
      vecs[2] = '{nch: 1, shift: 2, relu: 0, np: 1, p0: -6, p1: 0, p2: 0, p3: 0, exp: -1};
      vecs[3] = '{nch: 1, shift: 2, relu: 0, np: 1, p0: 5, p1: 0, p2: 0, p3: 0, exp: 1};
      vecs[4] = '{nch: 1, shift: 0, relu: 0, np: 1, p0: -7, p1: 0, p2: 0, p3: 0, exp: -7};
      vecs[5] = '{nch: 2, shift: 0, relu: 0, np: 2, p0: 524287, p1: 524287, p2: 0, p3: 0,
                  exp: 127};
      vecs[6] = '{nch: 2, shift: 0, relu: 0, np: 2, p0: -524288, p1: -524288, p2: 0, p3: 0,
                  exp: -128};
      vecs[7] = '{nch: 2, shift: 0, relu: 1, np: 2, p0: -524288, p1: -524288, p2: 0, p3: 0,
                  exp: 0};
      vecs[8] = '{nch: 0, shift: 0, relu: 0, np: 1, p0: 33, p1: 0, p2: 0, p3: 0, exp: 33};
      vecs[9] = '{nch: 4, shift: 3, relu: 0, np: 4, p0: 40, p1: 30, p2: 20, p3: 10, exp: 13};

      rst_n = 1'b0; start = 1'b0; cfg_num_ch = '0; cfg_num_px = '0; cfg_shift = '0;
      cfg_relu_en = 1'b0; psum_valid = 1'b0; psum_in = '0; ofm_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst.valid", ofm_valid, 0);
      chk("rst.data", ofm_data, 0);
      chk("rst.psum_ready", psum_ready, 0);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 10; i++) begin
         v = vecs[i];
         start_frame(v.nch, 1, v.shift, v.relu);
         chk($sformatf("vec%0d.busy", i), busy, 1);
         feed(v.p0);
         if (v.np > 1) feed(v.p1);
         if (v.np > 2) feed(v.p2);
         if (v.np > 3) feed(v.p3);
         take($sformatf("vec%0d", i), v.exp, 1'b1);
      end

      // Backpressure: result held, no psum consumed while stalled.
      start_frame(2, 2, 0, 0);
      feed(7);
      feed(8);
      psum_valid = 1'b1;
      psum_in    = 20'd99;
      for (int k = 0; k < 5; k++) begin
         chk("bp.hold_valid", ofm_valid, 1);
         chk("bp.hold_data", $signed(ofm_data), 15);
         chk("bp.hold_ready", psum_ready, 0);
         @(negedge clk);
      end
      psum_valid = 1'b0;
      ofm_ready  = 1'b1;
      @(negedge clk);
      ofm_ready  = 1'b0;
      chk("bp.done_mid", done, 0);
      chk("bp.busy_mid", busy, 1);
      chk("bp.psum_ready_mid", psum_ready, 1);
      feed(1);
      feed(2);
      take("bp.px2", 3, 1'b1);

      // Asynchronous reset mid-accumulation discards the partial sum.
      start_frame(4, 1, 0, 0);
      feed(5);
      feed(6);
      #2 rst_n = 1'b0;
      #1;
      chk("arst.valid", ofm_valid, 0);
      chk("arst.data", ofm_data, 0);
      chk("arst.psum_ready", psum_ready, 0);
      chk("arst.busy", busy, 0);
      chk("arst.done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_frame(4, 1, 0, 0);
      feed(1);
      feed(2);
      feed(3);
      feed(4);
      take("arst.after", 10, 1'b1);

      // Three-pixel frame with valid gaps and a spurious start mid-frame.
      base = done_cnt;
      start_frame(2, 3, 0, 0);
      for (int p = 0; p < 3; p++) begin
         int ps0, ps1, ex;
         ps0 = (p == 0) ? 3 : (p == 1) ? -5 : 100;
         ps1 = (p == 0) ? 4 : (p == 1) ? -6 : 27;
         ex  = (p == 0) ? 7 : (p == 1) ? -11 : 127;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (p == 1) start = 1'b1;
         feed(ps0);
         start = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         feed(ps1);
         for (int k = 0; k < 10 && ofm_valid !== 1'b1; k++) @(negedge clk);
         repeat ($urandom_range(0, 3)) @(negedge clk);
         chk($sformatf("frm.px%0d.ready_low", p), psum_ready, 0);
         take($sformatf("frm.px%0d", p), ex, p == 2);
      end
      repeat (2) @(negedge clk);
      chk("frm.done_count", done_cnt - base, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
